mac_arb_ctrl: RTL and testbench

Round-robin arbiter and sequencer that shares the single multiply-accumulate datapath between NREQ requesters. Each requester presents a request and a 2-bit function code; the block grants one requester at a time and drives the datapath control bus through the two pipeline stages (stage 1, stage 2). It then returns a one-cycle completion pulse to the granted requester. It sits between the requesting engines and the datapath control input, replacing direct single-master control.

---
 rtl/mac_arb_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mac_arb_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_arb_ctrl.sv
// mac_arb_ctrl
//   Shares the single multiply-accumulate datapath between NREQ requesters.
//   A winner is picked in IDLE. Its function code is captured once. The
//   block then walks the datapath control through stage 1 (S1) and
//   stage 2 (S2). On return to IDLE it pulses done to the winner for one
//   cycle.
//
//   Build option:
//     MAC_ARB_FIXED_PRIO_EN  defined   -> fixed priority, the lowest index
//                                         wins, and no rotating pointer exists
//                            undefined -> round robin starting at ptr
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     req       per-requester request level
//     func_in   function codes; bits [2i+1:2i] belong to requester i
//     grant     one-hot grant, held for S1 and S2
//     ctrl      control code to the datapath (00 when idle)
//     ctrl_vld  ctrl is valid (S1/S2)
//     state_c   current FSM state (00 IDLE, 01 S1, 10 S2)
//     done      one-cycle completion pulse to the finished requester
//     busy      high in S1/S2
//
//   All outputs come straight from flops.
module mac_arb_ctrl #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] func_in,
  output logic [NREQ-1:0]   grant,
  output logic [1:0]        ctrl,
  output logic              ctrl_vld,
  output logic [1:0]        state_c,
  output logic [NREQ-1:0]   done,
  output logic              busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    S_ILL = 2'b11
  } state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] grant_nx, done_nx;
  logic [1:0]      func_q, func_nx, ctrl_nx;
  logic            ctrl_vld_nx, busy_nx;

  // arbitration results
  logic [1:0]      func_arr [NREQ];
  logic [NREQ-1:0] elig, pick_oh;
  logic [PTR_W-1:0] start, pick, arb_idx;
  logic [1:0]      pick_func;
  logic            pick_found;

`ifdef MAC_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [PTR_W-1:0] ptr, ptr_nx, win_q, win_nx;
  assign start = ptr;
`endif

  assign state_c = state;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      func_arr[i] = func_in[2*i +: 2];
    end
  end

  // A requester in its own done cycle is not eligible. The search starts
  // at 'start' and wraps upward, so the first eligible index wins.
  always_comb begin
    elig       = req & ~done;
    pick       = '0;
    pick_oh    = '0;
    pick_func  = 2'b00;
    pick_found = 1'b0;
    arb_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_idx = PTR_W'((int'(start) + i) % NREQ);
      if (!pick_found && elig[arb_idx]) begin
        pick_found       = 1'b1;
        pick             = arb_idx;
        pick_oh[arb_idx] = 1'b1;
        pick_func        = func_arr[arb_idx];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    done_nx     = '0;
    func_nx     = func_q;
    ctrl_nx     = 2'b00;
    ctrl_vld_nx = 1'b0;
    busy_nx     = 1'b0;
`ifndef MAC_ARB_FIXED_PRIO_EN
    ptr_nx      = ptr;
    win_nx      = win_q;
`endif
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (pick_found) begin
          state_nx    = S1;
          grant_nx    = pick_oh;
          func_nx     = pick_func;
          ctrl_nx     = pick_func;
          ctrl_vld_nx = 1'b1;
          busy_nx     = 1'b1;
`ifndef MAC_ARB_FIXED_PRIO_EN
          win_nx      = pick;
`endif
        end
      end
      S1: begin
        state_nx    = S2;
        ctrl_nx     = func_q;
        ctrl_vld_nx = 1'b1;
        busy_nx     = 1'b1;
      end
      S2: begin
        state_nx = IDLE;
        grant_nx = '0;
        done_nx  = grant;
`ifndef MAC_ARB_FIXED_PRIO_EN
        ptr_nx   = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
`endif
      end
      default: begin
        // The unused encoding returns to IDLE with everything at rest.
        state_nx = IDLE;
        grant_nx = '0;
        func_nx  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      func_q   <= 2'b00;
      ctrl     <= 2'b00;
      ctrl_vld <= 1'b0;
      busy     <= 1'b0;
`ifndef MAC_ARB_FIXED_PRIO_EN
      ptr      <= '0;
      win_q    <= '0;
`endif
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      done     <= done_nx;
      func_q   <= func_nx;
      ctrl     <= ctrl_nx;
      ctrl_vld <= ctrl_vld_nx;
      busy     <= busy_nx;
`ifndef MAC_ARB_FIXED_PRIO_EN
      ptr      <= ptr_nx;
      win_q    <= win_nx;
`endif
    end
  end

  // pick is consumed only by the round-robin pointer logic
  logic unused_pick;
  assign unused_pick = ^pick;

endmodule

// File: tb/tb_mac_arb_ctrl.sv
// Bench for mac_arb_ctrl (NREQ = 4).
// A reference model tracks each operation as an age count after its grant
// (0 = S1, 1 = S2, 2 = done cycle). Outputs are derived from that age. A
// compare process checks every output on each falling edge. Directed
// sequences add literal expectations.
module tb_mac_arb_ctrl;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] func_in;
  logic [NREQ-1:0]   grant;
  logic [1:0]        ctrl;
  logic              ctrl_vld;
  logic [1:0]        state_c;
  logic [NREQ-1:0]   done;
  logic              busy;

  int n_vec;
  int n_miss;
  logic chk_en;

  mac_arb_ctrl #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .func_in  (func_in),
    .grant    (grant),
    .ctrl     (ctrl),
    .ctrl_vld (ctrl_vld),
    .state_c  (state_c),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    int         age;   // -1 idle, 0 first stage, 1 second stage, 2 done cycle
    int         win;
    int         ptr;
    logic [1:0] func;
  } model_t;

  localparam model_t M_RST = '{age: -1, win: 0, ptr: 0, func: 2'b00};

  model_t m;

  function automatic model_t model_step(model_t cur, logic [NREQ-1:0] r,
                                        logic [2*NREQ-1:0] f);
    model_t n;
    int mask;
    int elig;
    int first;
    int w;
    n = cur;
    if (cur.age == 0) begin
      n.age = 1;
    end else if (cur.age == 1) begin
      n.age = 2;
      n.ptr = (cur.win + 1) % NREQ;
    end else begin
      mask  = (cur.age == 2) ? (1 << cur.win) : 0;
      elig  = int'(r) & ~mask;
`ifdef MAC_ARB_FIXED_PRIO_EN
      first = 0;
`else
      first = cur.ptr;
`endif
      n.age = -1;
      for (int k = 0; k < NREQ; k++) begin
        w = (first + k) % NREQ;
        if (n.age == -1 && ((elig >> w) & 1) != 0) begin
          n.age  = 0;
          n.win  = w;
          n.func = 2'((f >> (2 * w)) & 3);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RST;
    else        m <= model_step(m, req, func_in);
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic            act_op;
    logic [NREQ-1:0] e_grant;
    logic [NREQ-1:0] e_done;
    logic [1:0]      e_ctrl;
    logic [1:0]      e_state;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        act_op  = (m.age == 0) || (m.age == 1);
        e_grant = act_op ? (NREQ'(1) << m.win) : '0;
        e_done  = (m.age == 2) ? (NREQ'(1) << m.win) : '0;
        e_ctrl  = act_op ? m.func : 2'b00;
        e_state = (m.age == 0) ? 2'b01 : (m.age == 1) ? 2'b10 : 2'b00;
        check("m_grant",    32'(grant),    32'(e_grant));
        check("m_done",     32'(done),     32'(e_done));
        check("m_ctrl",     32'(ctrl),     32'(e_ctrl));
        check("m_ctrl_vld", 32'(ctrl_vld), 32'(act_op));
        check("m_busy",     32'(busy),     32'(act_op));
        check("m_state",    32'(state_c),  32'(e_state));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rest(input string nm);
    check({nm, "_grant"},    32'(grant),    32'h0);
    check({nm, "_ctrl"},     32'(ctrl),     32'h0);
    check({nm, "_ctrl_vld"}, 32'(ctrl_vld), 32'h0);
    check({nm, "_state"},    32'(state_c),  32'h0);
    check({nm, "_done"},     32'(done),     32'h0);
    check({nm, "_busy"},     32'(busy),     32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    int ph;
    int widx;
    logic [NREQ-1:0] g_exp;
    n_vec   = 0;
    n_miss  = 0;
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    req     = '0;
    func_in = '0;
    repeat (2) step();
    check_rest("reset");
    chk_en = 1'b1;
    rst_n  = 1'b1;
    step();

    // single request from requester 2, func 11
    req     = 4'b0100;
    func_in = 8'b0011_0000;
    step();
    check("single_grant", 32'(grant),    32'h4);
    check("single_ctrl",  32'(ctrl),     32'h3);
    check("single_vld",   32'(ctrl_vld), 32'h1);
    check("single_st1",   32'(state_c),  32'h1);
    req     = '0;
    func_in = '0;
    step();
    check("single_st2",   32'(state_c),  32'h2);
    check("single_ctrl2", 32'(ctrl),     32'h3);
    step();
    check("single_done",  32'(done),     32'h4);
    check("single_idle",  32'(ctrl),     32'h0);
    check("single_gclr",  32'(grant),    32'h0);
    step();
    check("single_done1", 32'(done),     32'h0);

    // requester 1, func 01; func and req change during S1
    req     = 4'b0010;
    func_in = 8'b0000_0100;
    step();
    check("fchg_grant", 32'(grant), 32'h2);
    check("fchg_ctrl1", 32'(ctrl),  32'h1);
    func_in = 8'b0000_1000;
    req     = '0;
    step();
    check("fchg_ctrl2", 32'(ctrl),    32'h1);
    check("fchg_st2",   32'(state_c), 32'h2);
    step();
    check("fchg_done",  32'(done),    32'h2);
    step();

    // requester 2 keeps req high through its done cycle; requester 3 waits
    req     = 4'b0100;
    func_in = 8'b0110_0000;
    step();
    check("mask_grant2", 32'(grant), 32'h4);
    check("mask_ctrl2",  32'(ctrl),  32'h2);
    req = 4'b1100;
    step();
    step();
    check("mask_done2",  32'(done),  32'h4);
    step();
    check("mask_grant3", 32'(grant), 32'h8);
    check("mask_ctrl3",  32'(ctrl),  32'h1);
    req = '0;
    step();
    step();
    check("mask_done3",  32'(done),  32'h8);
    step();

    // all four requesting from reset; func code equals requester index
    rst_n   = 1'b0;
    req     = 4'b1111;
    func_in = 8'b11_10_01_00;
    step();
    rst_n = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      step();
      op = (s - 1) / 3;
      ph = (s - 1) % 3;
`ifdef MAC_ARB_FIXED_PRIO_EN
      // requester 0 is masked in its own done cycle, so 1 slips in between
      widx = op % 2;
`else
      widx = op % 4;
`endif
      g_exp = NREQ'(1) << widx;
      check("rr_grant", 32'(grant), (ph < 2)  ? 32'(g_exp) : 32'h0);
      check("rr_done",  32'(done),  (ph == 2) ? 32'(g_exp) : 32'h0);
      check("rr_ctrl",  32'(ctrl),  (ph < 2)  ? 32'(widx)  : 32'h0);
    end

    // reset asserted in the middle of S1
    req   = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req     = 4'b0010;
    func_in = 8'b0000_1100;
    step();
    check("rst_grant_pre", 32'(grant),   32'h2);
    check("rst_st_pre",    32'(state_c), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_rest("rst_async");
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_after_st",   32'(state_c), 32'h0);
    check("rst_after_done", 32'(done),    32'h0);
    step();
    check("rst_after_done2", 32'(done),   32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
